// File: rtl/fp_add_sub_13_if.sv
// Operand/result bundle for the binary32 adder/subtractor.
interface fp_add_sub_13_if;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;

  modport master (output op, output a, output b, input c);
  modport slave  (input op, input a, input b, output c);
endinterface

// File: rtl/fp_add_sub_13.sv
// Combinational IEEE-754 binary32 adder/subtractor, round-to-nearest-even.
// clk/rst exist only for pipeline interface uniformity.
module fp_add_sub_13 (
  input  logic           clk,
  input  logic           rst,
  fp_add_sub_13_if.slave bus
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, swap;
  logic        sl, ss;
  logic [7:0]  el, es, d;
  logic [23:0] ml, ms;
  logic [49:0] wide;
  logic [26:0] lx, sx, m;
  logic [27:0] sum;
  logic [9:0]  e, sh;
  logic [4:0]  lz;
  logic        inc;
  logic [24:0] mant;
  logic [31:0] res;

  always_comb begin
    sa = bus.a[31];
    sb = bus.b[31] ^ bus.op;
    ea = bus.a[30:23];
    eb = bus.b[30:23];
    fa = bus.a[22:0];
    fb = bus.b[22:0];
    a_nan = (&ea) & (|fa);
    b_nan = (&eb) & (|fb);
    a_inf = (&ea) & ~(|fa);
    b_inf = (&eb) & ~(|fb);

    // Finite encodings order by magnitude as unsigned integers.
    swap = bus.b[30:0] > bus.a[30:0];
    sl = swap ? sb : sa;
    ss = swap ? sa : sb;
    el = swap ? ((eb == 8'd0) ? 8'd1 : eb) : ((ea == 8'd0) ? 8'd1 : ea);
    es = swap ? ((ea == 8'd0) ? 8'd1 : ea) : ((eb == 8'd0) ? 8'd1 : eb);
    ml = swap ? {|eb, fb} : {|ea, fa};
    ms = swap ? {|ea, fa} : {|eb, fb};
    d  = el - es;

    // Layout of lx/sx: {significand[23:0], guard, round, sticky}
    wide = {ms, 26'b0} >> d;
    sx   = (d >= 8'd26) ? {26'b0, |ms} : {wide[49:24], |wide[23:0]};
    lx   = {ml, 3'b000};
    sum  = (sl == ss) ? ({1'b0, lx} + {1'b0, sx}) : ({1'b0, lx} - {1'b0, sx});

    e  = {2'b00, el};
    lz = '0;
    sh = '0;
    if (sum[27]) begin
      m = {sum[27:2], sum[1] | sum[0]};
      e = e + 10'd1;
    end else begin
      m  = sum[26:0];
      lz = lzc27(m);
      // Left shift stops at exponent 1, leaving a denormal.
      sh = ({5'b0, lz} < (e - 10'd1)) ? {5'b0, lz} : (e - 10'd1);
      m  = m << sh;
      e  = e - sh;
    end

    inc  = m[2] & (m[1] | m[0] | m[3]);
    mant = {1'b0, m[26:3]} + {24'b0, inc};
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 10'd1;
    end

    if (e >= 10'd255) begin
      res = {sl, 8'hFF, 23'b0};
    end else if (mant == 25'd0) begin
      // Only zero + zero of matching sign keeps a negative sign.
      res = {sl & ss, 31'b0};
    end else begin
      res = {sl, (mant[23] ? e[7:0] : 8'h00), mant[22:0]};
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      res = 32'h7FC0_0000;
    end else if (a_inf) begin
      res = {sa, 8'hFF, 23'b0};
    end else if (b_inf) begin
      res = {sb, 8'hFF, 23'b0};
    end

    bus.c = res;
  end

  c_known_a: assert property (@(posedge clk) disable iff (!rst) !$isunknown(bus.c));

endmodule

// File: tb/tb_fp_add_sub_13.sv
// Vector-table bench for fp_add_sub_13 with an expected-result queue.
module tb_fp_add_sub_13;

  logic clk;
  logic rst;
  logic clk_en;

  fp_add_sub_13_if bus ();

  fp_add_sub_13 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  function automatic void add(string n, logic o, logic [31:0] x, logic [31:0] y,
                              logic [31:0] z);
    vec_t v;
    v.name = n;
    v.op   = o;
    v.a    = x;
    v.b    = y;
    v.exp  = z;
    vecs.push_back(v);
  endfunction

  task automatic check_out();
    vec_t v;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got=%0d want=1", sb_q.size());
    end else begin
      v = sb_q.pop_front();
      checks++;
      if (bus.c !== v.exp) begin
        errors++;
        $display("FAIL %s op=%0b a=%08h b=%08h got=%08h want=%08h",
                 v.name, v.op, v.a, v.b, bus.c, v.exp);
      end
    end
  endtask

  task automatic apply(vec_t v);
    bus.op = v.op;
    bus.a  = v.a;
    bus.b  = v.b;
    sb_q.push_back(v);
    #1;
    check_out();
  endtask

  task automatic apply_raw(string n, logic o, logic [31:0] x, logic [31:0] y,
                           logic [31:0] z);
    vec_t v;
    v.name = n;
    v.op   = o;
    v.a    = x;
    v.b    = y;
    v.exp  = z;
    apply(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b1;
    rst    = 1'b0;
    bus.op = 1'b0;
    bus.a  = '0;
    bus.b  = '0;

    add("add_pp",       1'b0, 32'h4180_0000, 32'h3F80_0000, 32'h4188_0000);
    add("add_pn",       1'b0, 32'h4180_0000, 32'hBF80_0000, 32'h4170_0000);
    add("add_np",       1'b0, 32'hC180_0000, 32'h3F80_0000, 32'hC170_0000);
    add("add_nn",       1'b0, 32'hC180_0000, 32'hBF80_0000, 32'hC188_0000);
    add("tie_even",     1'b0, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    add("tie_odd_up",   1'b0, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
    add("cancel",       1'b1, 32'h4049_0FDB, 32'h4049_0FDB, 32'h0000_0000);
    add("overflow",     1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    add("denorm_add",   1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002);
    add("norm_to_den",  1'b1, 32'h0080_0000, 32'h0000_0001, 32'h007F_FFFF);
    add("inf_m_inf",    1'b1, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
    add("nan_a",        1'b0, 32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000);
    add("nan_b",        1'b1, 32'h3F80_0000, 32'h7F80_0001, 32'h7FC0_0000);
    add("ninf_fin",     1'b0, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
    add("fin_m_inf",    1'b1, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000);
    add("nz_nz",        1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    add("pz_nz",        1'b0, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    add("zero_denorm",  1'b0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0005);
    add("one_one",      1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    add("three_m_one",  1'b1, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
    add("far_small",    1'b0, 32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000);
    add("sub_tie_up",   1'b1, 32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000);

    // Reset asserted, inputs zero: output is the plain function value.
    #2;
    apply_raw("reset_state", 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

    rst = 1'b1;
    @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i]);

    // Clock frozen and reset held: result must still track inputs.
    clk_en = 1'b0;
    rst    = 1'b0;
    #3;
    apply_raw("sub_pp_rst", 1'b1, 32'h4180_0000, 32'h3F80_0000, 32'h4170_0000);
    apply_raw("sub_pn_rst", 1'b1, 32'h4180_0000, 32'hBF80_0000, 32'h4188_0000);
    apply_raw("sub_np_rst", 1'b1, 32'hC180_0000, 32'h3F80_0000, 32'hC188_0000);
    apply_raw("sub_nn_rst", 1'b1, 32'hC180_0000, 32'hBF80_0000, 32'hC170_0000);

    // Toggling reset alone must not disturb the held result.
    sb_q.push_back('{name: "rst_release", op: 1'b1, a: 32'hC180_0000,
                     b: 32'hBF80_0000, exp: 32'hC170_0000});
    rst = 1'b1;
    #1;
    check_out();

    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    apply_raw("op_flip", 1'b0, 32'hC180_0000, 32'hBF80_0000, 32'hC188_0000);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
